// File: rtl/mul_seq_pkg.sv
// Shared constants, state encoding and width helpers for the multiplier
// operand sequencer.
package mul_seq_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 1023;

    // Number of bits needed to index n entries, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_PTR_W = clog2_min1(DEF_FIFO_DEPTH);
    localparam int DEF_CNT_W = clog2_min1(DEF_TIMEOUT);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_LDA   = 3'd2;
    localparam state_t ST_LDB   = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_OUT   = 3'd5;

endpackage

// File: rtl/mul_pair_fifo.sv
// Synchronous FIFO holding {a, b} operand pairs; registered full/empty flags.
module mul_pair_fifo
    import mul_seq_pkg::*;
#(
    parameter int DATA_W = 2 * DEF_WIDTH,
    parameter int DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic              full_r;
    logic              empty_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign do_push_s = push & ~full_r;
    assign do_pop_s  = pop & ~empty_r;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage array: contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            empty_r <= (count_next_s == {CNT_W{1'b0}});
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = full_r;
    assign empty    = empty_r;

endmodule

// File: rtl/mul_operand_sequencer.sv
// Buffers operand pairs, serialises them onto the multiplier load bus,
// waits for done (with a watchdog) and presents the product.
module mul_operand_sequencer
    import mul_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_timeout,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_data,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_product,
    output logic             busy
);

    localparam int CNT_W = clog2_min1(TIMEOUT);

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   result_r;
    logic               timeout_r;
    logic               out_valid_r;
    logic               mul_start_r;
    logic [WIDTH-1:0]   mul_data_r;
    logic               fifo_pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [2*WIDTH-1:0] fifo_data_s;
    logic               expire_s;

    mul_pair_fifo #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_a, in_b}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_data_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign expire_s = (cnt_r == CNT_W'(TIMEOUT - 1));

    // Next-state decode; the FIFO is popped on every edge that enters START.
    always_comb begin
        state_next_s = state_r;
        fifo_pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_next_s = ST_START;
                    fifo_pop_s   = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: state_next_s = ST_LDA;
            ST_LDA:   state_next_s = ST_LDB;
            ST_LDB:   state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (mul_done || expire_s) begin
                    state_next_s = ST_OUT;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (out_ready && !fifo_empty_s) begin
                    state_next_s = ST_START;
                    fifo_pop_s   = 1'b1;
                end else if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, operand hold, watchdog, result capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            timeout_r   <= 1'b0;
            out_valid_r <= 1'b0;
            mul_start_r <= 1'b0;
            mul_data_r  <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (fifo_pop_s) begin
                {a_r, b_r} <= fifo_data_s;
            end
            // Watchdog restarts on LDB so every WAIT gets the full budget.
            if (state_r == ST_LDB) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_WAIT && state_next_s == ST_WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // Done outranks expiry when both land on the same edge.
            if (state_r == ST_WAIT && mul_done) begin
                result_r  <= mul_product;
                timeout_r <= 1'b0;
            end else if (state_r == ST_WAIT && expire_s) begin
                result_r  <= {WIDTH{1'b0}};
                timeout_r <= 1'b1;
            end else begin
                result_r  <= result_r;
                timeout_r <= timeout_r;
            end
            out_valid_r <= (state_next_s == ST_OUT);
            mul_start_r <= (state_next_s == ST_START);
            case (state_next_s)
                ST_LDA:  mul_data_r <= a_r;
                ST_LDB:  mul_data_r <= b_r;
                default: mul_data_r <= {WIDTH{1'b0}};
            endcase
        end
    end

    assign in_ready    = ~fifo_full_s;
    assign out_valid   = out_valid_r;
    assign out_result  = result_r;
    assign out_timeout = timeout_r;
    assign mul_start   = mul_start_r;
    assign mul_data    = mul_data_r;
    assign busy        = (state_r != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench: stimulus queues expected results, a multiplier model
// answers the load bus, and a monitor checks every presented result.
module tb_mul_operand_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0;
    logic [15:0] in_b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_timeout;
    logic        mul_start;
    logic [15:0] mul_data;
    logic        mul_done = 1'b0;
    logic [15:0] mul_product = 16'h0;
    logic        busy;

    mul_operand_sequencer #(.WIDTH(16), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_timeout(out_timeout), .mul_start(mul_start),
        .mul_data(mul_data), .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    bit   stk_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_out_cyc = -1;
    int   ph = 0;
    bit   pushing = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model: takes A and B off the bus after start, then raises
    // done after a random latency; done stays high until the next op's WAIT.
    initial begin
        logic [15:0] cap_a;
        logic [15:0] cap_b;
        logic [31:0] prod;
        int          lat;
        bit          cur_stuck;
        cap_a = 16'h0;
        cap_b = 16'h0;
        lat = 0;
        cur_stuck = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ph = 0;
                mul_done = 1'b0;
            end else begin
                case (ph)
                    0: begin
                        chk("bus_idle", {16'h0, mul_data}, 32'h0);
                        if (mul_start) begin
                            if (stk_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL spurious_start: got start expected none (cycle %0d)", cyc);
                                cur_stuck = 1'b0;
                            end else begin
                                cur_stuck = stk_q.pop_front();
                            end
                            ph = 1;
                        end
                    end
                    1: begin
                        chk("start_one_cycle", {31'h0, mul_start}, 32'h0);
                        cap_a = mul_data;
                        ph = 2;
                    end
                    2: begin
                        chk("start_low_ldb", {31'h0, mul_start}, 32'h0);
                        cap_b = mul_data;
                        lat = $urandom_range(0, 6);
                        exp_out_cyc = cur_stuck ? (cyc + 1 + TO) : (cyc + 1 + lat + 2);
                        ph = 3;
                    end
                    3: begin
                        mul_done = 1'b0;
                        mul_product = 16'($urandom);
                        ph = cur_stuck ? 0 : 4;
                    end
                    4: begin
                        chk("bus_wait", {16'h0, mul_data}, 32'h0);
                        if (lat == 0) begin
                            prod = cap_a * cap_b;
                            mul_product = prod[15:0];
                            mul_done = 1'b1;
                            ph = 0;
                        end else begin
                            lat--;
                        end
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    // Monitor: latency of each new result, stability under backpressure,
    // and in-order comparison against the scoreboard on every handshake.
    initial begin
        bit          prev_valid;
        bit          prev_hs;
        bit          prev_rst;
        logic [16:0] prev_word;
        exp_t        e;
        prev_valid = 1'b0;
        prev_hs = 1'b0;
        prev_rst = 1'b1;
        prev_word = 17'h0;
        forever begin
            @(negedge clk);
            if (rst || prev_rst) begin
                prev_valid = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (out_valid && !(prev_valid && !prev_hs)) begin
                    chk("out_latency", cyc, exp_out_cyc);
                end
                if (prev_valid && !prev_hs) begin
                    chk("held_valid", {31'h0, out_valid}, 32'h1);
                    chk("held_result", {15'h0, out_timeout, out_result}, {15'h0, prev_word});
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %0h expected no result", out_result);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {16'h0, out_result}, {16'h0, e.res});
                        chk("timeout_flag", {31'h0, out_timeout}, {31'h0, e.to});
                    end
                end
                prev_valid = out_valid;
                prev_hs = out_valid && out_ready;
                prev_word = {out_timeout, out_result};
            end
            prev_rst = rst;
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input bit stuck);
        bit          ok;
        logic [31:0] p;
        exp_t        e;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) begin
            p = a * b;
            e.res = stuck ? 16'h0 : p[15:0];
            e.to = stuck;
            exp_q.push_back(e);
            stk_q.push_back(stuck);
        end else begin
            checks++;
            errors++;
            $display("FAIL push_accept: got in_ready=0 for 300 cycles expected acceptance");
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #2 out_ready = v;
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        chk("drain_queue", exp_q.size(), 32'h0);
        chk("drain_idle", {31'h0, busy}, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_out_result"}, {16'h0, out_result}, 32'h0);
        chk({tag, "_out_timeout"}, {31'h0, out_timeout}, 32'h0);
        chk({tag, "_mul_start"}, {31'h0, mul_start}, 32'h0);
        chk({tag, "_mul_data"}, {16'h0, mul_data}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int starts;
        int seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // Single op with exact bus timing.
        set_ready(1'b1);
        push(16'd17, 16'd5, 1'b0);
        @(negedge clk);
        chk("single_no_start_yet", {31'h0, mul_start}, 32'h0);
        chk("single_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("single_start", {31'h0, mul_start}, 32'h1);
        chk("single_bus_start", {16'h0, mul_data}, 32'h0);
        @(negedge clk);
        chk("single_bus_a", {16'h0, mul_data}, 32'd17);
        @(negedge clk);
        chk("single_bus_b", {16'h0, mul_data}, 32'd5);
        @(negedge clk);
        chk("single_bus_wait", {16'h0, mul_data}, 32'h0);
        wait_drain(200);

        // Burst of five: four buffered plus one in flight fills the FIFO.
        push(16'd3, 16'd4, 1'b0);
        push(16'd7, 16'd0, 1'b0);
        push(16'd255, 16'd255, 1'b0);
        push(16'd1, 16'd1, 1'b0);
        push(16'd300, 16'd300, 1'b0);
        @(negedge clk);
        chk("burst_in_ready_low", {31'h0, in_ready}, 32'h0);
        wait_drain(400);

        // Backpressure: result held, no new start, FIFO full.
        set_ready(1'b0);
        for (int i = 0; i < 5; i++) push(16'($urandom), 16'($urandom), 1'b0);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        chk("bp_result_presented", {31'h0, out_valid}, 32'h1);
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            if (mul_start) starts++;
        end
        chk("bp_no_start", starts, 32'h0);
        chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
        set_ready(1'b1);
        wait_drain(400);

        // Stuck multiplier, then a normal op.
        push(16'h1234, 16'h0002, 1'b1);
        wait_drain(200);
        push(16'd9, 16'd9, 1'b0);
        wait_drain(200);

        // Randomized mix with random backpressure.
        pushing = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    push(($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom),
                         $urandom_range(0, 9) == 0);
                end
                pushing = 1'b0;
            end
            begin
                while (pushing) begin
                    @(posedge clk);
                    #2 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        set_ready(1'b1);
        wait_drain(1000);

        // Reset while in WAIT with two pairs queued.
        push(16'd11, 16'd13, 1'b0);
        push(16'd21, 16'd23, 1'b0);
        push(16'd31, 16'd33, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        stk_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || mul_start) seen++;
        end
        chk("midrst_no_activity", seen, 32'h0);
        push(16'd100, 16'd200, 1'b0);
        wait_drain(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within 50000 cycles");
        $fatal(1, "bench timed out");
    end

endmodule
